// File: rtl/sideband_serializer.sv
// sideband_serializer: byte FIFO feeding a start/data/stop bit framer that
// drives a sideband line one bit per clock. The line idles high.
// Optional even-parity bit after the data bits when SB_SER_PARITY_EN is defined.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high, waiting for enable and a buffered byte
// START  | start bit (0) being issued
// DATA   | data bits LSB-first, cnt counts 0..DATA_WIDTH-1
// PARITY | even parity of the data bits (SB_SER_PARITY_EN only)
// STOP   | stop bit (1); chains straight into START if another byte waits
//
// out_bit and busy are registered from the current state, so the line lags
// the state register by one clock.
module sideband_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          data_valid,
   output logic                          data_ready,
   input  logic                          enable,
   output logic                          out_bit,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                 state, state_next;
   logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic                   push, pop;
   logic [DATA_WIDTH-1:0]  sr;
   logic [CNT_W-1:0]       cnt;
   logic                   out_next;
`ifdef SB_SER_PARITY_EN
   logic                   par;
`endif

   // A pop in the same cycle does not open a slot: no push-through when full.
   assign data_ready = !rst && (fifo_level != LVL_FULL);
   assign push       = data_valid && data_ready;

   // FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Next-state, pop request and next line value.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      out_next   = 1'b1;
      case (state)
         IDLE: begin
            if (enable && (fifo_level != '0)) begin
               pop        = 1'b1;
               state_next = START;
            end
         end
         START: begin
            out_next   = 1'b0;
            state_next = DATA;
         end
         DATA: begin
            out_next = sr[0];
            if (cnt == CNT_LAST) begin
`ifdef SB_SER_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef SB_SER_PARITY_EN
         PARITY: begin
            out_next   = par;
            state_next = STOP;
         end
`endif
         STOP: begin
            out_next = 1'b1;
            if (enable && (fifo_level != '0)) begin
               pop        = 1'b1;
               state_next = START;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Shift register and bit counter; the head byte is loaded on pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else begin
         if (pop)                sr <= mem[rd_ptr];
         else if (state == DATA) sr <= sr >> 1;
         if (state == START)     cnt <= '0;
         else if (state == DATA) cnt <= cnt + 1'b1;
      end
   end

`ifdef SB_SER_PARITY_EN
   // Parity is taken from the whole byte at load time, before it shifts away.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      par <= 1'b0;
      else if (pop) par <= ^mem[rd_ptr];
   end
`endif

   // State register and registered line outputs; reset forces the line idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         out_bit <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_next;
         out_bit <= out_next;
         busy    <= (state != IDLE);
      end
   end

endmodule

// File: tb/tb_sideband_serializer.sv
// Bench for sideband_serializer: directed scenarios plus a randomized run
// compared against a frame-level model (expected line = framed accepted bytes).
module tb_sideband_serializer;

   localparam int DW = 8;
   localparam int FD = 4;
`ifdef SB_SER_PARITY_EN
   localparam int FL = DW + 3;
`else
   localparam int FL = DW + 2;
`endif

   logic            clk;
   logic            rst;
   logic [DW-1:0]   data_in;
   logic            data_valid;
   logic            data_ready;
   logic            enable;
   logic            out_bit;
   logic            busy;
   logic [$clog2(FD):0] fifo_level;

   int checks   = 0;
   int failures = 0;
   logic exp_q[$];

   sideband_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .enable     (enable),
      .out_bit    (out_bit),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference framing: start 0, data LSB-first, optional even parity, stop 1.
   task automatic add_frame(input logic [DW-1:0] b);
      exp_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_q.push_back(b[i]);
`ifdef SB_SER_PARITY_EN
      exp_q.push_back(^b);
`endif
      exp_q.push_back(1'b1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; data_valid = 1'b0; enable = 1'b0; data_in = '0;
      tick(); tick();
      checks++; if (out_bit !== 1'b1) begin failures++; $display("FAIL reset_out_bit got=%b exp=1", out_bit); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", data_ready); end
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      rst = 1'b0;
      tick();
      checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", data_ready); end
   endtask

   task automatic test_single();
      logic [FL-1:0] rx;
      rx = '0;
      enable = 1'b1; data_in = 8'hA5; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL single_level_push got=%0d exp=1", fifo_level); end
      tick();
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL single_level_pop got=%0d exp=0", fifo_level); end
      checks++; if (out_bit !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_pre_start got out=%b busy=%b exp out=1 busy=0", out_bit, busy); end
      exp_q.delete();
      add_frame(8'hA5);
      for (int k = 0; k < FL; k++) begin
         tick();
         rx[k] = out_bit;
         checks++; if (out_bit !== exp_q[k]) begin failures++; $display("FAIL single_bit%0d got=%b exp=%b", k, out_bit, exp_q[k]); end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy%0d got=%b exp=1", k, busy); end
      end
`ifndef SB_SER_PARITY_EN
      checks++; if (rx !== 10'h34A) begin failures++; $display("FAIL single_rx_word got=%h exp=34a", rx); end
`endif
      tick();
      checks++; if (out_bit !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_idle got out=%b busy=%b exp out=1 busy=0", out_bit, busy); end
   endtask

   task automatic test_back_to_back();
      enable = 1'b1; data_valid = 1'b1; data_in = 8'h00;
      tick();
      data_in = 8'hFF;
      tick();
      data_valid = 1'b0;
      checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL b2b_push_pop_level got=%0d exp=1", fifo_level); end
      exp_q.delete();
      add_frame(8'h00);
      add_frame(8'hFF);
      for (int k = 0; k < 2 * FL; k++) begin
         tick();
         checks++; if (out_bit !== exp_q[k]) begin failures++; $display("FAIL b2b_bit%0d got=%b exp=%b", k, out_bit, exp_q[k]); end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy%0d got=%b exp=1", k, busy); end
      end
      tick();
      checks++; if (out_bit !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got out=%b busy=%b exp out=1 busy=0", out_bit, busy); end
   endtask

   task automatic test_fifo_full();
      logic [DW-1:0] b [5];
      int idx;
      logic rdy;
      for (int i = 0; i < 5; i++) b[i] = DW'($urandom);
      enable = 1'b0; idx = 0; data_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         data_in = b[idx];
         rdy = data_ready;
         tick();
         if (rdy && idx < 4) idx++;
         else if (rdy) begin
            failures++; checks++;
            $display("FAIL full_extra_accept got=accept exp=hold");
         end
      end
      checks++; if (idx !== 4) begin failures++; $display("FAIL full_accepts got=%0d exp=4", idx); end
      checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", data_ready); end
      checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
      checks++; if (out_bit !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL full_held_idle got out=%b busy=%b exp out=1 busy=0", out_bit, busy); end
      data_in = b[4];
      enable = 1'b1;
      tick();
      checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL full_first_pop_level got=%0d exp=3", fifo_level); end
      checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", data_ready); end
      tick();
      data_valid = 1'b0;
      checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_fifth_accept_level got=%0d exp=4", fifo_level); end
      exp_q.delete();
      for (int i = 0; i < 5; i++) add_frame(b[i]);
      for (int k = 0; k < 5 * FL; k++) begin
         if (k > 0) tick();
         checks++; if (out_bit !== exp_q[k] || busy !== 1'b1) begin failures++; $display("FAIL full_stream_bit%0d got out=%b busy=%b exp out=%b busy=1", k, out_bit, busy, exp_q[k]); end
      end
      tick();
      checks++; if (out_bit !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL full_idle got out=%b busy=%b exp out=1 busy=0", out_bit, busy); end
   endtask

   task automatic test_enable_drop();
      logic [DW-1:0] q;
      q = DW'($urandom);
      enable = 1'b1; data_valid = 1'b1; data_in = 8'h3C;
      tick();
      data_in = q;
      tick();
      data_valid = 1'b0;
      exp_q.delete();
      add_frame(8'h3C);
      for (int k = 0; k < FL; k++) begin
         tick();
         checks++; if (out_bit !== exp_q[k] || busy !== 1'b1) begin failures++; $display("FAIL drop_bit%0d got out=%b busy=%b exp out=%b busy=1", k, out_bit, busy, exp_q[k]); end
         if (k == 4) enable = 1'b0;
      end
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++; if (out_bit !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd1) begin failures++; $display("FAIL drop_hold%0d got out=%b busy=%b level=%0d exp out=1 busy=0 level=1", c, out_bit, busy, fifo_level); end
      end
      enable = 1'b1;
      tick();
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL drop_resume_pop got=%0d exp=0", fifo_level); end
      exp_q.delete();
      add_frame(q);
      for (int k = 0; k < FL; k++) begin
         tick();
         checks++; if (out_bit !== exp_q[k] || busy !== 1'b1) begin failures++; $display("FAIL drop_resume_bit%0d got out=%b busy=%b exp out=%b busy=1", k, out_bit, busy, exp_q[k]); end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] b [3];
      logic [DW-1:0] c;
      for (int i = 0; i < 3; i++) b[i] = DW'($urandom);
      c = DW'($urandom);
      enable = 1'b1; data_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_in = b[i];
         tick();
      end
      data_valid = 1'b0;
      checks++; if (out_bit !== 1'b0 || fifo_level !== 3'd2) begin failures++; $display("FAIL rstmid_setup got out=%b level=%0d exp out=0 level=2", out_bit, fifo_level); end
      for (int k = 0; k < 6; k++) tick();
      checks++; if (out_bit !== b[0][5]) begin failures++; $display("FAIL rstmid_bit5 got=%b exp=%b", out_bit, b[0][5]); end
      rst = 1'b1;
      #1;
      checks++; if (out_bit !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_async got out=%b busy=%b exp out=1 busy=0", out_bit, busy); end
      checks++; if (data_ready !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL rstmid_fifo got ready=%b level=%0d exp ready=0 level=0", data_ready, fifo_level); end
      tick(); tick();
      checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready_held got=%b exp=0", data_ready); end
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         checks++; if (out_bit !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL rstmid_quiet%0d got out=%b busy=%b level=%0d exp out=1 busy=0 level=0", k, out_bit, busy, fifo_level); end
      end
      data_in = c; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      tick();
      exp_q.delete();
      add_frame(c);
      for (int k = 0; k < FL; k++) begin
         tick();
         checks++; if (out_bit !== exp_q[k] || busy !== 1'b1) begin failures++; $display("FAIL rstmid_new_bit%0d got out=%b busy=%b exp out=%b busy=1", k, out_bit, busy, exp_q[k]); end
      end
      tick();
   endtask

`ifdef SB_SER_PARITY_EN
   task automatic test_parity();
      enable = 1'b1; data_in = 8'h07; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      tick();
      exp_q.delete();
      add_frame(8'h07);
      for (int k = 0; k < FL; k++) begin
         tick();
         checks++; if (out_bit !== exp_q[k] || busy !== 1'b1) begin failures++; $display("FAIL parity_bit%0d got out=%b busy=%b exp out=%b busy=1", k, out_bit, busy, exp_q[k]); end
      end
      tick();
      checks++; if (out_bit !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL parity_idle got out=%b busy=%b exp out=1 busy=0", out_bit, busy); end
   endtask
`endif

   task automatic test_random();
      logic obs_q[$];
      int accepts, idle_run, cyc, bad;
      logic rdy, v;
      logic [DW-1:0] d;
      exp_q.delete();
      accepts = 0; idle_run = 0; cyc = 0; bad = 0;
      while (cyc < 6000 && !(accepts >= 60 && idle_run >= 3)) begin
         if (accepts < 60) begin
            data_valid = ($urandom_range(0, 2) != 0);
            data_in    = DW'($urandom);
            enable     = ($urandom_range(0, 9) != 0);
         end else begin
            data_valid = 1'b0;
            enable     = 1'b1;
         end
         rdy = data_ready; v = data_valid; d = data_in;
         tick();
         cyc++;
         if (rdy && v) begin
            add_frame(d);
            accepts++;
         end
         if (busy) begin
            obs_q.push_back(out_bit);
            idle_run = 0;
         end else begin
            checks++; if (out_bit !== 1'b1) begin failures++; $display("FAIL rand_idle_line cycle=%0d got=%b exp=1", cyc, out_bit); end
            if (fifo_level == 0) idle_run++;
            else idle_run = 0;
         end
         checks++; if (data_ready !== (fifo_level != 3'd4) || fifo_level > 3'd4) begin failures++; $display("FAIL rand_ready cycle=%0d got ready=%b level=%0d exp ready=(level!=4)", cyc, data_ready, fifo_level); end
      end
      checks++; if (idle_run < 3) begin failures++; $display("FAIL rand_drain got=timeout exp=drained within budget"); end
      checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_stream_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            failures++;
            if (bad < 5) $display("FAIL rand_stream_bit%0d got=%b exp=%b", k, obs_q[k], exp_q[k]);
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fifo_full();
      test_enable_drop();
      test_reset_mid();
`ifdef SB_SER_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
